gpio_reg_initiator: RTL and testbench
=====================================

# gpio_reg_initiator

Bus-side initiator for the GPIO register file. It accepts single read/write requests on a valid/ready command port, turns them into register-bus cycles (`gpio_addr`, `gpio_we`, write data) and captures registered read data. It returns each result on a valid/ready response port. When enabled, it also services `gpio_inta_o` by itself: it reads RGPIO_INTS, clears it, and reports the captured status.

## Interface
- `AUTO_CLR`, 1: 1 = autonomous interrupt service enabled; 0 = `gpio_inta_o` ignored.
- `INTS_ADDR`, 32'h1c: address of RGPIO_INTS.
- `MAX_ADDR`, 32'h24: highest legal register address (RGPIO_NEC).

Ports:
- `sys_clk`  in  1  single clock; every flop is in this domain.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when high together with `req_valid` at a `sys_clk` edge.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  register byte address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  read data (0 for writes and errors).
- `rsp_err`  out  1  illegal address; no bus cycle issued.
- `gpio_addr`  out  32  register-bus address.
- `gpio_we`  out  1  register-bus write strobe.
- `gpio_dat_i`  out  32  register-bus write data.
- `gpio_dat_o`  in  32  register-bus read data; registered by the target, so it is valid one cycle after the address.
- `gpio_inta_o`  in  1  interrupt from the register file.
- `irq_valid`  out  1  one-cycle pulse when interrupt service completes.
- `irq_status`  out  32  INTS value captured by the last service.

## Operation
States: IDLE, WR, RD_ADDR, RD_CAP, RSP, IRQ_RD_ADDR, IRQ_RD_CAP, IRQ_CLR.

- **IDLE:**
  - `req_ready` = 1 only when `AUTO_CLR`==0 or `gpio_inta_o`==0.
  - If `AUTO_CLR` and `gpio_inta_o`, go to IRQ_RD_ADDR. The interrupt has priority over a simultaneous `req_valid`.
  - Otherwise, on accept:
    - Illegal address → RSP with `rsp_err`=1. An address is illegal when `req_addr[1:0]`!=0, or `req_addr` > `MAX_ADDR`, or it is a write to 0x0 (RGPIO_IN is read-only).
    - Legal write → WR.
    - Legal read → RD_ADDR.
  - The accepted address and data are latched.
- **WR:** `gpio_addr` = latched address, `gpio_dat_i` = latched data, `gpio_we` = 1 for exactly this cycle. Next state RSP with `rsp_rdata` = 0, `rsp_err` = 0.
- **RD_ADDR:** drive `gpio_addr`, `gpio_we` = 0. Next state RD_CAP.
- **RD_CAP:** hold `gpio_addr`; capture `gpio_dat_o` into `rsp_rdata` at the end of the cycle. Next state RSP.
- **RSP:** `rsp_valid` = 1. `rsp_rdata` and `rsp_err` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- **IRQ_RD_ADDR / IRQ_RD_CAP:** same as the read path, at `INTS_ADDR`; the captured value goes to `irq_status`.
- **IRQ_CLR:** `gpio_addr` = `INTS_ADDR`, `gpio_dat_i` = 0, `gpio_we` = 1 for one cycle. `irq_valid` pulses in this same cycle. Next state IDLE.

Held values:
- `gpio_addr` and `gpio_dat_i` hold their last driven value outside active states.
- `gpio_we` is 0 in every state except WR and IRQ_CLR.

## Timing
- **Reset values:** all outputs 0, state IDLE. `req_ready` returns to 1 in the first cycle after reset deasserts (provided `gpio_inta_o` is low or `AUTO_CLR` is 0).
- **Reset mid-operation:** state returns to IDLE asynchronously and `gpio_we` drops immediately. No pending response survives the reset.
- **Latencies, with accept at edge N:**
  - Write: `gpio_we` high in cycle N+1; `rsp_valid` rises in cycle N+2.
  - Read: address on the bus in cycles N+1 and N+2; data captured at the end of N+2; `rsp_valid` rises in N+3.
  - Error: `rsp_valid` rises in N+1.
- **Throughput:** one request outstanding. With `rsp_ready` tied high, the best case is one write per 3 cycles and one read per 4 cycles.
- **Interrupt service:** 3 cycles from entering IRQ_RD_ADDR to `irq_valid`.
  - `gpio_inta_o` falls in the cycle after IRQ_CLR.
  - An interrupt edge landing in the IRQ_CLR cycle itself is overwritten by the clear. This is accepted behaviour.
  - If `gpio_inta_o` is still high back in IDLE (a new event), the block re-enters service and `req_ready` stays 0.
- **Stall:** `rsp_ready` low stalls only the RSP state. Interrupt service never interrupts a transaction in flight.

## Test plan
- **Reset:** assert `sys_rst` mid-stream → all outputs 0; `req_ready`=1 one cycle after release; no `gpio_we` glitch.
- **Write then read:**
  - Write 0x4 with data 0xA5A50F0F → `gpio_we` high exactly 1 cycle with addr 0x4 and data 0xA5A50F0F; `rsp_valid` 2 cycles after accept, `rsp_err`=0.
  - Read 0x4 → `rsp_rdata`=0xA5A50F0F, `rsp_valid` 3 cycles after accept.
- **Errors:** each of read 0x26, read 0x28, write 0x0 → `rsp_err`=1 and `rsp_rdata`=0 one cycle after accept; `gpio_we` never asserted.
- **Auto interrupt** (`AUTO_CLR`=1): write INTE=0x1, PTRIG=0x1, CTRL=0x1, then drive `in_pad_i[0]` 0→1 → reads of 0x1c, then write of 0 to 0x1c; `irq_valid` pulse with `irq_status`=0x1; `gpio_inta_o` low afterwards.
- **Priority:** `req_valid` (read 0x8) and `gpio_inta_o` rise in the same IDLE cycle → service runs first, `req_ready`=0 throughout; the request is accepted the cycle after IRQ_CLR and returns the OE value.
- **Backpressure:** hold `rsp_ready` low for 5 cycles on a read of 0x14 → `rsp_valid`/`rsp_rdata` stable all 5 cycles, `req_ready`=0 and no bus activity; IDLE one cycle after `rsp_ready` rises.

Source files
------------

// File: rtl/gpio_reg_initiator_if.sv
// gpio_reg_initiator_if
//   Groups the command port, the response port, the register-bus signals and
//   the interrupt report of gpio_reg_initiator into one bundle.
//   master : the initiator side. It receives commands, drives the register
//            bus and produces responses and interrupt reports.
//   slave  : the opposite side. It issues commands and consumes responses,
//            and it also models the register file behind the bus.
interface gpio_reg_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] gpio_addr;
    logic        gpio_we;
    logic [31:0] gpio_dat_i;
    logic [31:0] gpio_dat_o;
    logic        gpio_inta_o;
    logic        irq_valid;
    logic [31:0] irq_status;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
               gpio_dat_o, gpio_inta_o,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               gpio_addr, gpio_we, gpio_dat_i, irq_valid, irq_status
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
               gpio_dat_o, gpio_inta_o,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               gpio_addr, gpio_we, gpio_dat_i, irq_valid, irq_status
    );
endinterface

// File: rtl/gpio_reg_initiator.sv
// gpio_reg_initiator
//   Bus-side initiator for the GPIO register file. It accepts one read or
//   write command at a time and turns it into a register-bus cycle. It returns
//   the result on a valid/ready response port. When AUTO_CLR is set, it also
//   services gpio_inta_o by itself: it reads INTS, writes 0 back to clear it,
//   and reports the captured status.
// Ports
//   sys_clk : single clock
//   sys_rst : asynchronous, active-high reset
//   bus     : command (req_*), response (rsp_*), register bus (gpio_*) and
//             interrupt report (irq_*) signals, master side
module gpio_reg_initiator #(
    parameter bit          AUTO_CLR  = 1'b1,
    parameter logic [31:0] INTS_ADDR = 32'h1c,
    parameter logic [31:0] MAX_ADDR  = 32'h24
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    gpio_reg_initiator_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAP,
        RSP,
        IRQ_RD_ADDR,
        IRQ_RD_CAP,
        IRQ_CLR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] irq_status_q, irq_status_d;
    logic        ready;
    logic        irq_pending;
    logic        addr_illegal;

    assign irq_pending  = AUTO_CLR && bus.gpio_inta_o;

    // RGPIO_IN at address 0 is read-only, so a write to it is rejected.
    assign addr_illegal = (bus.req_addr[1:0] != 2'b00)
                       || (bus.req_addr > MAX_ADDR)
                       || (bus.req_write && (bus.req_addr == '0));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdat_q       <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            irq_status_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdat_q       <= wdat_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            irq_status_q <= irq_status_d;
        end
    end

    // The bus registers are loaded on the edge that enters the active state.
    // The write strobe is set the same way, so it is a clean flop output that
    // is high for exactly one cycle in WR or IRQ_CLR.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdat_d       = wdat_q;
        we_d         = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        irq_status_d = irq_status_q;
        ready        = 1'b0;

        case (state_q)
            IDLE: begin
                if (irq_pending) begin
                    addr_d  = INTS_ADDR;
                    state_d = IRQ_RD_ADDR;
                end else begin
                    ready = 1'b1;
                    if (bus.req_valid) begin
                        rdata_d = '0;
                        err_d   = addr_illegal;
                        if (addr_illegal) begin
                            // Rejected: no bus cycle, so the bus keeps its last values.
                            state_d = RSP;
                        end else if (bus.req_write) begin
                            addr_d  = bus.req_addr;
                            wdat_d  = bus.req_wdata;
                            we_d    = 1'b1;
                            state_d = WR;
                        end else begin
                            addr_d  = bus.req_addr;
                            state_d = RD_ADDR;
                        end
                    end
                end
            end
            WR:          state_d = RSP;
            RD_ADDR:     state_d = RD_CAP;
            RD_CAP: begin
                rdata_d = bus.gpio_dat_o;
                state_d = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            IRQ_RD_ADDR: state_d = IRQ_RD_CAP;
            IRQ_RD_CAP: begin
                irq_status_d = bus.gpio_dat_o;
                wdat_d       = '0;
                we_d         = 1'b1;
                state_d      = IRQ_CLR;
            end
            IRQ_CLR:     state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // req_ready is combinational from the state, so it is gated by reset to
    // keep every output at 0 while reset is held.
    assign bus.req_ready  = ready && !sys_rst;
    assign bus.rsp_valid  = (state_q == RSP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = err_q;
    assign bus.gpio_addr  = addr_q;
    assign bus.gpio_we    = we_q;
    assign bus.gpio_dat_i = wdat_q;
    assign bus.irq_valid  = (state_q == IRQ_CLR);
    assign bus.irq_status = irq_status_q;

endmodule

// File: tb/tb_gpio_reg_initiator.sv
module tb_gpio_reg_initiator;

    localparam logic [31:0] INTS   = 32'h1c;
    localparam logic [31:0] MAXA   = 32'h24;
    localparam logic [31:0] IN_VAL = 32'h1357_9bdf;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   irq_cnt;
    int   rsp_mode;     // 0 random, 1 held low, 2 held high

    gpio_reg_initiator_if bus ();

    gpio_reg_initiator #(
        .AUTO_CLR  (1'b1),
        .INTS_ADDR (INTS),
        .MAX_ADDR  (MAXA)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    // ---------------- register-file target ----------------
    logic [31:0] mem [16];
    logic        irq_set;
    logic [31:0] irq_bits;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            bus.gpio_dat_o <= '0;
        end else begin
            if (irq_set) mem[7] <= mem[7] | irq_bits;
            if (bus.gpio_we) mem[bus.gpio_addr[5:2]] <= bus.gpio_dat_i;
            bus.gpio_dat_o <= (bus.gpio_addr[5:2] == 4'd0) ? IN_VAL : mem[bus.gpio_addr[5:2]];
        end
    end
    assign bus.gpio_inta_o = |mem[7];

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] model [logic [31:0]];
    exp_t        exp_q [$];
    logic [63:0] wq [$];
    logic [31:0] irq_q [$];
    logic [31:0] addrs [14];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == 32'h0) return IN_VAL;
        if (model.exists(a)) return model[a];
        return 32'h0;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_mode == 0) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            else               bus.rsp_ready = (rsp_mode == 2);
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t        e;
        logic [63:0] w;
        logic [31:0] s;
        bit          prev_v;
        bit          chk_low;
        bit          rst_prev;
        logic [31:0] prev_rdata;
        logic        prev_err;
        prev_v = 0; chk_low = 0; rst_prev = 0; irq_cnt = 0;
        prev_rdata = '0; prev_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (bus.req_ready || bus.rsp_valid || bus.rsp_err || bus.gpio_we || bus.irq_valid
                    || bus.rsp_rdata != 0 || bus.gpio_addr != 0 || bus.gpio_dat_i != 0 || bus.irq_status != 0) begin
                    errors++;
                    $display("FAIL reset_outputs got rdy=%b v=%b err=%b we=%b irqv=%b rdata=%h addr=%h dat=%h st=%h want all 0",
                             bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.gpio_we, bus.irq_valid,
                             bus.rsp_rdata, bus.gpio_addr, bus.gpio_dat_i, bus.irq_status);
                end
                prev_v = 0; chk_low = 0; rst_prev = 1;
            end else begin
                if (rst_prev) begin
                    checks++;
                    if (bus.req_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL ready_after_reset got=%b want=1", bus.req_ready);
                    end
                end
                rst_prev = 0;

                // response port
                if (bus.rsp_valid) begin
                    if (!prev_v) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rsp_unexpected rdata=%h err=%b want no response", bus.rsp_rdata, bus.rsp_err);
                        end else if (cyc - exp_q[0].acc + 1 != exp_q[0].lat) begin
                            errors++;
                            $display("FAIL rsp_latency got=%0d want=%0d", cyc - exp_q[0].acc + 1, exp_q[0].lat);
                        end
                    end else begin
                        checks++;
                        if (bus.rsp_rdata != prev_rdata || bus.rsp_err != prev_err) begin
                            errors++;
                            $display("FAIL rsp_stable got=%h/%b want=%h/%b", bus.rsp_rdata, bus.rsp_err, prev_rdata, prev_err);
                        end
                    end
                    checks++;
                    if (bus.req_ready || bus.gpio_we) begin
                        errors++;
                        $display("FAIL rsp_quiet got rdy=%b we=%b want 0/0", bus.req_ready, bus.gpio_we);
                    end
                    if (bus.rsp_ready && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (bus.rsp_rdata != e.rdata || bus.rsp_err != e.err) begin
                            errors++;
                            $display("FAIL rsp_data got=%h/%b want=%h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                        end
                    end
                end
                prev_v     = bus.rsp_valid && !bus.rsp_ready;
                prev_rdata = bus.rsp_rdata;
                prev_err   = bus.rsp_err;

                // register-bus writes
                if (bus.gpio_we) begin
                    checks++;
                    if (bus.gpio_addr == INTS) begin
                        if (bus.gpio_dat_i != 0 || !bus.irq_valid) begin
                            errors++;
                            $display("FAIL irq_clear got dat=%h irqv=%b want 0/1", bus.gpio_dat_i, bus.irq_valid);
                        end
                    end else if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL we_unexpected addr=%h dat=%h want no write", bus.gpio_addr, bus.gpio_dat_i);
                    end else begin
                        w = wq.pop_front();
                        if ({bus.gpio_addr, bus.gpio_dat_i} != w) begin
                            errors++;
                            $display("FAIL bus_write got=%h/%h want=%h/%h", bus.gpio_addr, bus.gpio_dat_i, w[63:32], w[31:0]);
                        end
                    end
                end

                // interrupt service
                if (bus.irq_valid) begin
                    irq_cnt++;
                    checks++;
                    if (irq_q.size() == 0) begin
                        errors++;
                        $display("FAIL irq_unexpected status=%h want no service", bus.irq_status);
                    end else begin
                        s = irq_q.pop_front();
                        if (bus.irq_status != s) begin
                            errors++;
                            $display("FAIL irq_status got=%h want=%h", bus.irq_status, s);
                        end
                    end
                    chk_low = 1;
                end else if (chk_low) begin
                    checks++;
                    if (bus.gpio_inta_o) begin
                        errors++;
                        $display("FAIL inta_cleared got=1 want=0");
                    end
                    chk_low = 0;
                end

                if (bus.gpio_inta_o) begin
                    checks++;
                    if (bus.req_ready) begin
                        errors++;
                        $display("FAIL ready_during_irq got=1 want=0");
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, output int acc);
        exp_t e;
        bit   legal;
        bit   done;
        legal = (a % 4 == 0) && (a <= MAXA) && !(w && a == 0);
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        done = 0;
        acc  = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        bus.req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr=%h got no accept want accept within 300 cycles", a);
            return;
        end
        acc   = cyc;
        e.acc = cyc;
        if (!legal) begin
            e.rdata = 0; e.err = 1; e.lat = 1;
        end else if (w) begin
            e.rdata = 0; e.err = 0; e.lat = 2;
            wq.push_back({a, d});
            model[a] = d;
        end else begin
            e.rdata = model_read(a); e.err = 0; e.lat = 3;
        end
        exp_q.push_back(e);
    endtask

    task automatic start_irq(input logic [31:0] bits);
        @(negedge clk);
        irq_set  = 1'b1;
        irq_bits = bits;
        irq_q.push_back(bits);
        @(posedge clk);
        #1;
        irq_set = 1'b0;
    endtask

    task automatic wait_irq(input int start);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (irq_cnt != start) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL irq_timeout got no irq_valid want pulse within 400 cycles");
        end
    endtask

    task automatic trig(input logic [31:0] bits);
        int s;
        s = irq_cnt;
        start_irq(bits);
        wait_irq(s);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && (exp_q.size() != 0 || wq.size() != 0 || irq_q.size() != 0); i++)
            @(negedge clk);
    endtask

    initial begin : main
        int acc;
        int cyc0;
        int s;
        checks = 0; errors = 0; rsp_mode = 2;
        irq_set = 1'b0; irq_bits = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        addrs = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h18, 32'h20,
                  32'h24, 32'h26, 32'h28, 32'h2, 32'h40, 32'hffff_fffc};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // directed write/read and error cases
        issue(1'b1, 32'h4, 32'ha5a5_0f0f, acc);
        issue(1'b0, 32'h4, 32'h0, acc);
        issue(1'b0, 32'h26, 32'h0, acc);
        issue(1'b0, 32'h28, 32'h0, acc);
        issue(1'b1, 32'h0, 32'hdead_beef, acc);
        issue(1'b0, 32'h0, 32'h0, acc);

        // interrupt setup and autonomous service
        issue(1'b1, 32'h8, 32'h0000_00f3, acc);
        issue(1'b1, 32'hc, 32'h1, acc);
        issue(1'b1, 32'h10, 32'h1, acc);
        issue(1'b1, 32'h18, 32'h1, acc);
        wait_drain();
        trig(32'h1);

        // interrupt and request in the same idle cycle
        wait_drain();
        s = irq_cnt;
        start_irq(32'h2);
        cyc0 = cyc;
        issue(1'b0, 32'h8, 32'h0, acc);
        checks++;
        if (acc - cyc0 != 5) begin
            errors++;
            $display("FAIL priority_accept got=%0d want=5 cycles", acc - cyc0);
        end
        wait_irq(s);

        // backpressure on a read
        issue(1'b1, 32'h14, 32'h5a5a_1234, acc);
        wait_drain();
        rsp_mode = 1;
        issue(1'b0, 32'h14, 32'h0, acc);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        rsp_mode = 2;
        wait_drain();

        // reset with a read in flight
        issue(1'b0, 32'h18, 32'h0, acc);
        #2 rst = 1'b1;
        exp_q.delete();
        wq.delete();
        model.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b0, 32'h4, 32'h0, acc);
        wait_drain();

        // randomized traffic with interleaved interrupts
        rsp_mode = 0;
        fork
            begin
                bit          w;
                logic [31:0] a;
                int          acc_r;
                for (int i = 0; i < 150; i++) begin
                    w = 1'($urandom_range(0, 1));
                    a = addrs[$urandom_range(0, 13)];
                    issue(w, a, $urandom, acc_r);
                end
            end
            begin
                logic [31:0] b;
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(5, 40)) @(negedge clk);
                    b = $urandom;
                    if (b == 0) b = 32'h8000_0000;
                    trig(b);
                end
            end
        join

        wait_drain();
        if (exp_q.size() != 0 || wq.size() != 0 || irq_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got rsp=%0d wr=%0d irq=%0d pending want 0", exp_q.size(), wq.size(), irq_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
